// File: rtl/stream_demux_pkt.sv
// Packet-aware 1:N AXI-stream demultiplexer: the destination is locked on the first beat and held
// until the last beat. Out-of-range packets are dropped and counted.
package stream_demux_pkt_pkg;
    typedef logic [31:0] payload_t;
    typedef struct packed {
        payload_t t;
        logic     tvalid;
    } axis_req_t;
    typedef struct packed {
        logic tready;
    } axis_resp_t;
endpackage

module stream_demux_pkt #(
    parameter type         payload_t   = stream_demux_pkt_pkg::payload_t,
    parameter type         axis_req_t  = stream_demux_pkt_pkg::axis_req_t,
    parameter type         axis_resp_t = stream_demux_pkt_pkg::axis_resp_t,
    parameter int unsigned MasterNum   = 4,
    parameter int unsigned SelW        = $clog2(MasterNum) + 1,
    parameter bit          PktMode     = 1'b1,
    parameter bit          InBypass    = 1'b0,
    parameter bit          DropInvalid = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  axis_req_t       s_axis_req,
    output axis_resp_t      s_axis_resp,
    input  logic [SelW-1:0] s_sel,
    input  logic            s_last,
    output axis_req_t       m_axis_req  [MasterNum],
    input  axis_resp_t      m_axis_resp [MasterNum],
    output logic            busy,
    output logic [SelW-1:0] cur_sel,
    output logic [15:0]     drop_cnt
);
    localparam int unsigned DestW = $clog2(MasterNum);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

    logic            h_valid;
    payload_t        h_data;
    logic [SelW-1:0] h_sel;
    logic            h_last;
    logic            pop_rdy;
    logic            consume;

    generate
        if (InBypass) begin : g_bypass
            assign h_valid            = s_axis_req.tvalid;
            assign h_data             = s_axis_req.t;
            assign h_sel              = s_sel;
            assign h_last             = s_last;
            assign s_axis_resp.tready = reset & pop_rdy;
        end else begin : g_skid
            typedef struct packed {
                payload_t        data;
                logic [SelW-1:0] sel;
                logic            last;
            } beat_t;

            beat_t      mem_q [2];
            logic       wr_ptr_q;
            logic       rd_ptr_q;
            logic [1:0] count_q;
            logic [1:0] count_d;
            logic       not_full_q;
            logic       push;

            assign push    = s_axis_req.tvalid & s_axis_resp.tready;
            assign count_d = count_q + {1'b0, push} - {1'b0, consume};

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= '{data: s_axis_req.t, sel: s_sel, last: s_last};
                end
            end

            // tready is gated by reset so it is low during reset and high on the first cycle after.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_ptr_q   <= 1'b0;
                    rd_ptr_q   <= 1'b0;
                    count_q    <= 2'd0;
                    not_full_q <= 1'b1;
                end else begin
                    wr_ptr_q   <= wr_ptr_q ^ push;
                    rd_ptr_q   <= rd_ptr_q ^ consume;
                    count_q    <= count_d;
                    not_full_q <= (count_d != 2'd2);
                end
            end

            assign h_valid            = (count_q != 2'd0);
            assign h_data             = mem_q[rd_ptr_q].data;
            assign h_sel              = mem_q[rd_ptr_q].sel;
            assign h_last             = mem_q[rd_ptr_q].last;
            assign s_axis_resp.tready = reset & not_full_q;
        end
    endgenerate

    state_e           state_q, state_d;
    logic [DestW-1:0] dest_q, dest_d;
    logic [DestW-1:0] d;
    logic [DestW-1:0] new_dest;
    logic             in_range;
    logic             act_fwd, act_drop, pkt_end;
    logic             busy_q, busy_d;
    logic [SelW-1:0]  cur_sel_q, cur_sel_d;
    logic [15:0]      drop_q, drop_d;

    assign in_range = (h_sel < SelW'(MasterNum));
    assign new_dest = in_range ? h_sel[DestW-1:0] : DestW'(MasterNum - 1);

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        d         = dest_q;
        act_fwd   = 1'b0;
        act_drop  = 1'b0;
        pop_rdy   = 1'b0;
        consume   = 1'b0;
        pkt_end   = 1'b0;
        busy_d    = busy_q;
        cur_sel_d = cur_sel_q;
        drop_d    = drop_q;

        // The IDLE decision is combinational so a new packet starts in the same cycle it arrives.
        case (state_q)
            IDLE: begin
                if (in_range || !DropInvalid) begin
                    act_fwd = 1'b1;
                    d       = new_dest;
                end else begin
                    act_drop = 1'b1;
                end
            end
            FWD:     act_fwd  = 1'b1;
            DROP:    act_drop = 1'b1;
            default: act_drop = 1'b0;
        endcase

        pop_rdy = act_fwd ? m_axis_resp[d].tready : act_drop;
        consume = h_valid & pop_rdy;
        pkt_end = consume & (h_last | !PktMode);

        if (state_q == IDLE && h_valid) begin
            state_d = act_fwd ? FWD : DROP;
            dest_d  = d;
        end
        if (pkt_end) begin
            state_d = IDLE;
        end

        if (consume) begin
            busy_d = !h_last;
            if (!busy_q) begin
                cur_sel_d = act_fwd ? SelW'(d) : h_sel;
            end
        end
        if (pkt_end && act_drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            busy_q    <= 1'b0;
            cur_sel_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            busy_q    <= busy_d;
            cur_sel_q <= cur_sel_d;
            drop_q    <= drop_d;
        end
    end

    for (genvar gi = 0; gi < MasterNum; gi++) begin : g_master
        assign m_axis_req[gi].t      = h_data;
        assign m_axis_req[gi].tvalid = h_valid & act_fwd & (d == DestW'(gi));
    end

    assign busy     = busy_q;
    assign cur_sel  = cur_sel_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_stream_demux_pkt.sv
// Directed bench for stream_demux_pkt: a packet-mode and a per-beat-mode instance share one stimulus
// stream; a scoreboard of {master, payload} entries is checked at every master handshake.
module tb_stream_demux_pkt;
    import stream_demux_pkt_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    axis_req_t  s_req, s_req_b;
    axis_resp_t s_resp_a, s_resp_b;
    logic [2:0] s_sel;
    logic       s_last;
    logic       en_b;
    axis_req_t  m_req_a [4];
    axis_req_t  m_req_b [4];
    axis_resp_t m_resp  [4];
    logic       busy_a, busy_b;
    logic [2:0] cur_sel_a, cur_sel_b;
    logic [15:0] drop_a, drop_b;

    logic [3:0]       vld_a, vld_b, rdy;
    logic [3:0][31:0] dat_a, dat_b;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int stalls = 0;
    int last_hs = 0;
    int exp_drop_a = 0;
    int exp_drop_b = 0;
    bit open_a = 0;
    int lock_a = 0;
    logic [35:0] q_a [$];
    logic [35:0] q_b [$];
    int hs_a [$];
    logic [3:0]       stall_q [2];
    logic [3:0][31:0] pdat_q  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        s_req_b.t      = s_req.t;
        s_req_b.tvalid = s_req.tvalid & en_b;
        for (int i = 0; i < 4; i++) begin
            vld_a[i] = m_req_a[i].tvalid;
            dat_a[i] = m_req_a[i].t;
            vld_b[i] = m_req_b[i].tvalid;
            dat_b[i] = m_req_b[i].t;
            rdy[i]   = m_resp[i].tready;
        end
    end

    stream_demux_pkt u_dut_a (
        .clk(clk), .reset(reset), .s_axis_req(s_req), .s_axis_resp(s_resp_a),
        .s_sel(s_sel), .s_last(s_last), .m_axis_req(m_req_a), .m_axis_resp(m_resp),
        .busy(busy_a), .cur_sel(cur_sel_a), .drop_cnt(drop_a)
    );

    stream_demux_pkt #(.PktMode(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .s_axis_req(s_req_b), .s_axis_resp(s_resp_b),
        .s_sel(s_sel), .s_last(s_last), .m_axis_req(m_req_b), .m_axis_resp(m_resp),
        .busy(busy_b), .cur_sel(cur_sel_b), .drop_cnt(drop_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks AXIS rules and pops the scoreboard on every master handshake of one instance.
    task automatic mon(input int k, input logic [3:0] vld, input logic [3:0][31:0] dat);
        int nv = 0;
        logic [35:0] e;
        for (int i = 0; i < 4; i++) nv += int'(vld[i]);
        if (nv != 0) chk("onehot_tvalid", 64'(nv), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (stall_q[k][i]) begin
                chk("hold_tvalid", 64'(vld[i]), 64'd1);
                chk("hold_payload", 64'(dat[i]), 64'(pdat_q[k][i]));
            end
            if (vld[i] && rdy[i]) begin
                $display("[%0d] dut%0d m[%0d] beat %08h", cyc + 1, k, i, dat[i]);
                if (k == 0) begin
                    hs_a.push_back(cyc + 1);
                    chk("sb_nonempty_a", 64'(q_a.size() != 0), 64'd1);
                    if (q_a.size() != 0) begin
                        e = q_a.pop_front();
                        chk("route_a", 64'({4'(i), dat[i]}), 64'(e));
                    end
                end else begin
                    chk("sb_nonempty_b", 64'(q_b.size() != 0), 64'd1);
                    if (q_b.size() != 0) begin
                        e = q_b.pop_front();
                        chk("route_b", 64'({4'(i), dat[i]}), 64'(e));
                    end
                end
            end
        end
        stall_q[k] = vld & ~rdy;
        pdat_q[k]  = dat;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            stall_q[0] = '0;
            stall_q[1] = '0;
        end else begin
            mon(0, vld_a, dat_a);
            mon(1, vld_b, dat_b);
        end
    end

    // Drives one beat, updates the reference model and waits for the slave handshake.
    task automatic send(input logic [31:0] data, input logic [2:0] sel, input logic last);
        bit got = 0;
        if (!open_a) lock_a = (sel < 3'd4) ? int'(sel) : -1;
        if (lock_a >= 0) q_a.push_back({4'(lock_a), data});
        else if (last && exp_drop_a < 65535) exp_drop_a++;
        open_a = !last;
        if (en_b) begin
            if (sel < 3'd4) q_b.push_back({4'(sel), data});
            else if (exp_drop_b < 65535) exp_drop_b++;
        end
        s_req.t      = data;
        s_req.tvalid = 1'b1;
        s_sel        = sel;
        s_last       = last;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (s_resp_a.tready && (!en_b || s_resp_b.tready)) begin
                got     = 1;
                last_hs = cyc + 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        chk("s_handshake", 64'(got), 64'd1);
    endtask

    task automatic idle();
        s_req.tvalid = 1'b0;
        s_last       = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", 64'(q_a.size() + q_b.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int first_hs;
        reset  = 1'b0;
        s_req  = '0;
        s_sel  = '0;
        s_last = 1'b0;
        en_b   = 1'b0;
        for (int i = 0; i < 4; i++) m_resp[i].tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 64'(s_resp_a.tready), 64'd0);
        chk("rst_tvalid", 64'(vld_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_cur_sel", 64'(cur_sel_a), 64'd0);
        chk("rst_drop", 64'(drop_a), 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_tready", 64'(s_resp_a.tready), 64'd1);

        // 1: back-to-back packets to m[2] then m[0], no gaps
        hs_a.delete();
        stalls = 0;
        send(32'h101, 3'd2, 1'b0);
        first_hs = last_hs;
        send(32'h102, 3'd2, 1'b0);
        chk("t1_busy", 64'(busy_a), 64'd1);
        chk("t1_cur_sel", 64'(cur_sel_a), 64'd2);
        send(32'h103, 3'd2, 1'b1);
        send(32'h201, 3'd0, 1'b0);
        send(32'h202, 3'd0, 1'b1);
        idle();
        drain();
        chk("t1_stalls", 64'(stalls), 64'd0);
        chk("t1_nbeats", 64'(hs_a.size()), 64'd5);
        for (int j = 0; j < 5 && j < hs_a.size(); j++) chk("t1_cycle", 64'(hs_a[j]), 64'(first_hs + 1 + j));
        chk("t1_busy_end", 64'(busy_a), 64'd0);

        // 2: backpressure on m[1] toggling 1,0,0,1
        stalls = 0;
        fork
            begin
                for (int j = 0; j < 4; j++) send(32'h301 + 32'(j), 3'd1, 1'(j == 3));
                idle();
            end
            begin
                m_resp[1].tready = 1'b1; @(posedge clk); #1;
                m_resp[1].tready = 1'b0; @(posedge clk); #1;
                m_resp[1].tready = 1'b0; @(posedge clk); #1;
                m_resp[1].tready = 1'b1;
            end
        join
        drain();
        chk("t2_s_stalls", 64'(stalls), 64'd2);

        // 3: dropped packet then immediate single-beat packet to m[3]
        en_b = 1'b1;
        hs_a.delete();
        send(32'h501, 3'd5, 1'b0);
        send(32'h502, 3'd5, 1'b0);
        send(32'h503, 3'd5, 1'b1);
        send(32'h600, 3'd3, 1'b1);
        first_hs = last_hs;
        idle();
        drain();
        chk("t3_drop_a", 64'(drop_a), 64'(exp_drop_a));
        chk("t3_drop_b", 64'(drop_b), 64'(exp_drop_b));
        chk("t3_m3_cycle", 64'(hs_a.size() == 1 ? hs_a[0] : -1), 64'(first_hs + 1));

        // 4: sel changes mid-packet; locked in packet mode, per beat otherwise
        send(32'h701, 3'd1, 1'b0);
        send(32'h702, 3'd3, 1'b0);
        send(32'h703, 3'd3, 1'b0);
        send(32'h704, 3'd3, 1'b1);
        idle();
        drain();
        en_b = 1'b0;

        // 5: reset in the middle of an open packet
        send(32'h801, 3'd2, 1'b0);
        send(32'h802, 3'd2, 1'b0);
        idle();
        drain();
        chk("t5_busy_open", 64'(busy_a), 64'd1);
        chk("t5_cur_sel", 64'(cur_sel_a), 64'd2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        open_a = 0;
        exp_drop_a = 0;
        exp_drop_b = 0;
        chk("t5_rst_tready", 64'(s_resp_a.tready), 64'd0);
        chk("t5_rst_tvalid", 64'(vld_a), 64'd0);
        chk("t5_rst_busy", 64'(busy_a), 64'd0);
        chk("t5_rst_drop", 64'(drop_a), 64'(exp_drop_a));
        reset = 1'b1;
        #1;
        chk("t5_rel_tready", 64'(s_resp_a.tready), 64'd1);
        send(32'h901, 3'd0, 1'b0);
        send(32'h902, 3'd0, 1'b1);
        idle();
        drain();

        // 6: drop counter saturation
        for (int j = 0; j < 65534; j++) send(32'(j), 3'd5, 1'b1);
        idle();
        drain();
        chk("t6_drop_fffe", 64'(drop_a), 64'(exp_drop_a));
        send(32'hA000, 3'd6, 1'b1);
        idle();
        drain();
        chk("t6_drop_ffff", 64'(drop_a), 64'(exp_drop_a));
        send(32'hA001, 3'd7, 1'b1);
        idle();
        drain();
        chk("t6_drop_sat", 64'(drop_a), 64'(exp_drop_a));
        chk("t6_busy", 64'(busy_a), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
